hydra_ingress_port: RTL

- Per-port ingress adapter sitting directly upstream of the hydra switch core; one instance per port, 16 total.
- Accepts a raw payload stream from the port MAC side and stores each packet whole (store-and-forward).
- Re-emits each packet on the core's write interface as: SOP cycle, header word, payload words, EOP cycle.
- Holds off starting new packets while the core asserts pause for this port.

---
 rtl/hydra_ingress_port_if.sv | 30 +++
 rtl/hydra_ingress_port.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hydra_ingress_port_if.sv
// Bundle of the MAC-side ingress stream and the core-side write stream for one hydra port.
// slave is the adapter's view; master is the MAC/core (or bench) view.
interface hydra_ingress_port_if;
  // Ingress words transfer on a clock edge where in_vld && in_ready; in_ready is registered
  // and does not depend on in_vld, and the sender holds in_vld/data/last/dest/prio until accepted.
  logic        in_vld;
  logic [15:0] in_data;
  logic        in_last;
  logic [3:0]  in_dest;
  logic [2:0]  in_prio;
  logic        in_ready;
  logic        pause;
  logic        wr_sop;
  logic        wr_vld;
  logic [15:0] wr_data;
  logic        wr_eop;
  logic        pkt_trunc;
  logic [15:0] pkt_count;
  logic [2:0]  dbg_state;

  modport master (
    output in_vld, in_data, in_last, in_dest, in_prio, pause,
    input  in_ready, wr_sop, wr_vld, wr_data, wr_eop, pkt_trunc, pkt_count, dbg_state
  );

  modport slave (
    input  in_vld, in_data, in_last, in_dest, in_prio, pause,
    output in_ready, wr_sop, wr_vld, wr_data, wr_eop, pkt_trunc, pkt_count, dbg_state
  );
endinterface

// File: rtl/hydra_ingress_port.sv
// Store-and-forward ingress adapter: buffers whole packets, then emits SOP / header / payload / EOP
// to the switch core, holding off new packets while the core pauses this port.
module hydra_ingress_port #(
  parameter int DEPTH      = 512,
  parameter int META_DEPTH = 8,
  parameter int MAX_LEN    = 511
) (
  input logic                  clk,
  input logic                  rst_n,
  hydra_ingress_port_if.slave  bus
);

  localparam int DW = $clog2(DEPTH);
  localparam int MW = $clog2(META_DEPTH);
  localparam logic [DW:0]   DATA_LIMIT = (DW+1)'(DEPTH);
  localparam logic [DW:0]   DATA_ONE   = (DW+1)'(1);
  localparam logic [DW-1:0] DPTR_ONE   = DW'(1);
  localparam logic [MW:0]   META_LIMIT = (MW+1)'(META_DEPTH);
  localparam logic [MW:0]   META_ONE   = (MW+1)'(1);
  localparam logic [MW-1:0] MPTR_ONE   = MW'(1);
  localparam logic [8:0]    MAX_LEN_C  = 9'(MAX_LEN);

  typedef enum logic [2:0] {S_IDLE, S_SOP, S_HDR, S_DATA, S_EOP} state_t;

  logic [15:0]   data_mem [DEPTH];
  logic [DW-1:0] dwr_ptr, drd_ptr;
  logic [DW:0]   data_cnt, data_cnt_n;
  logic [15:0]   meta_mem [META_DEPTH];
  logic [MW-1:0] mwr_ptr, mrd_ptr;
  logic [MW:0]   meta_cnt, meta_cnt_n;

  logic        in_ready_q, in_acc;
  logic [8:0]  in_cnt, in_cnt_inc;
  logic [3:0]  dest_q, cur_dest;
  logic [2:0]  prio_q, cur_prio;
  logic        discard, first_word, hit_max;
  logic        data_push, meta_push, trunc_evt;
  logic [15:0] meta_wdata;

  state_t      state_q, state_n;
  logic [8:0]  out_cnt;
  logic [15:0] meta_head;
  logic [8:0]  hdr_len;
  logic        meta_avail, start, data_pop, meta_pop;
  logic        sop_d, vld_d, eop_d;
  logic [15:0] data_d;
  logic        sop_q, vld_q, eop_q, trunc_q;
  logic [15:0] wdata_q, pkt_count_q;

  // Ingress side: dest/prio come from the first word; a single-word packet uses them directly.
  assign in_acc     = bus.in_vld && in_ready_q;
  assign first_word = (in_cnt == 9'd0);
  assign cur_dest   = first_word ? bus.in_dest : dest_q;
  assign cur_prio   = first_word ? bus.in_prio : prio_q;
  assign in_cnt_inc = in_cnt + 9'd1;
  assign hit_max    = (in_cnt_inc == MAX_LEN_C);
  assign data_push  = in_acc && !discard;
  assign meta_push  = data_push && (bus.in_last || hit_max);
  assign trunc_evt  = data_push && hit_max && !bus.in_last;
  assign meta_wdata = {in_cnt_inc, cur_prio, cur_dest};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt  <= '0;
      dest_q  <= '0;
      prio_q  <= '0;
      discard <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      trunc_q <= trunc_evt;
      if (data_push) begin
        if (first_word) begin
          dest_q <= bus.in_dest;
          prio_q <= bus.in_prio;
        end
        in_cnt <= meta_push ? 9'd0 : in_cnt_inc;
        if (trunc_evt) discard <= 1'b1;
      end else if (in_acc && bus.in_last) begin
        // Tail of a truncated packet ends here; nothing was stored for it.
        discard <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (data_push) data_mem[dwr_ptr] <= bus.in_data;
    if (meta_push) meta_mem[mwr_ptr] <= meta_wdata;
  end

  // Egress: the meta head being sent is popped in EOP, so a follow-on packet needs a second entry.
  assign meta_head  = meta_mem[mrd_ptr];
  assign hdr_len    = meta_head[15:7];
  assign meta_avail = (state_q == S_EOP) ? (meta_cnt > META_ONE) : (meta_cnt != '0);
  assign start      = meta_avail && !bus.pause;
  assign data_pop   = (state_n == S_DATA);
  assign meta_pop   = (state_q == S_EOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (start) state_n = S_SOP;
      S_SOP:   state_n = S_HDR;
      S_HDR:   state_n = S_DATA;
      S_DATA:  if (out_cnt == hdr_len) state_n = S_EOP;
      S_EOP:   state_n = start ? S_SOP : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with state_q.
  always_comb begin
    sop_d  = (state_n == S_SOP);
    vld_d  = (state_n == S_HDR) || (state_n == S_DATA);
    eop_d  = (state_n == S_EOP);
    data_d = '0;
    if (state_n == S_HDR)       data_d = meta_head;
    else if (state_n == S_DATA) data_d = data_mem[drd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sop_q       <= 1'b0;
      vld_q       <= 1'b0;
      eop_q       <= 1'b0;
      wdata_q     <= '0;
      out_cnt     <= '0;
      pkt_count_q <= '0;
    end else begin
      sop_q   <= sop_d;
      vld_q   <= vld_d;
      eop_q   <= eop_d;
      wdata_q <= data_d;
      if (state_q == S_SOP) out_cnt <= '0;
      else if (data_pop)    out_cnt <= out_cnt + 9'd1;
      if (meta_pop) pkt_count_q <= pkt_count_q + 16'd1;
    end
  end

  // Occupancy bookkeeping; in_ready looks at next-cycle occupancy so it can never overrun.
  always_comb begin
    data_cnt_n = data_cnt;
    if (data_push && !data_pop)      data_cnt_n = data_cnt + DATA_ONE;
    else if (!data_push && data_pop) data_cnt_n = data_cnt - DATA_ONE;
    meta_cnt_n = meta_cnt;
    if (meta_push && !meta_pop)      meta_cnt_n = meta_cnt + META_ONE;
    else if (!meta_push && meta_pop) meta_cnt_n = meta_cnt - META_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwr_ptr    <= '0;
      drd_ptr    <= '0;
      data_cnt   <= '0;
      mwr_ptr    <= '0;
      mrd_ptr    <= '0;
      meta_cnt   <= '0;
      in_ready_q <= 1'b0;
    end else begin
      if (data_push) dwr_ptr <= dwr_ptr + DPTR_ONE;
      if (data_pop)  drd_ptr <= drd_ptr + DPTR_ONE;
      if (meta_push) mwr_ptr <= mwr_ptr + MPTR_ONE;
      if (meta_pop)  mrd_ptr <= mrd_ptr + MPTR_ONE;
      data_cnt   <= data_cnt_n;
      meta_cnt   <= meta_cnt_n;
      in_ready_q <= (data_cnt_n < DATA_LIMIT) && (meta_cnt_n < META_LIMIT);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.wr_sop    = sop_q;
  assign bus.wr_vld    = vld_q;
  assign bus.wr_data   = wdata_q;
  assign bus.wr_eop    = eop_q;
  assign bus.pkt_trunc = trunc_q;
  assign bus.pkt_count = pkt_count_q;
  assign bus.dbg_state = state_q;

endmodule
